// File: rtl/data_buffer.sv
// 64x8 byte FIFO for the USB transmit path; pushes land in occupancy on the next edge, and pops register the byte on the same edge.
// No handshake: a push into a full buffer (without a pop) or a pop from an empty one is silently dropped.
module data_buffer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       store_tx_data,
  input  logic       get_tx_packet_data,
  input  logic       clear,
  output logic [6:0] buffer_occupancy,
  output logic [7:0] tx_packet_data
);

  localparam int DEPTH = 64;
  localparam int WIDTH = 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [5:0]       wptr;
  logic [5:0]       rptr;
  logic             pop_ok;
  logic             push_ok;
  logic             flush;

  assign flush  = n_rst || clear;
  assign pop_ok = get_tx_packet_data && (buffer_occupancy != 7'd0);
  // When full, a concurrent pop frees the oldest slot, so the push may reuse it.
  assign push_ok = store_tx_data && ((buffer_occupancy != 7'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr             <= '0;
      rptr             <= '0;
      buffer_occupancy <= '0;
      tx_packet_data   <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 6'd1;
      end
      if (pop_ok) begin
        rptr           <= rptr + 6'd1;
        tx_packet_data <= mem[rptr];
      end
      buffer_occupancy <= buffer_occupancy + {6'd0, push_ok} - {6'd0, pop_ok};
    end
  end

endmodule

// File: tb/tb_data_buffer.sv
// Bench for data_buffer: fixed vector table, directed corner sequences, and randomized traffic against a queue model.
module tb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       store_tx_data = 1'b0;
  logic       get_tx_packet_data = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] model_q[$];
  logic [7:0] model_out = 8'h00;

  always #5 clk = ~clk;

  data_buffer dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_data            (tx_data),
    .store_tx_data      (store_tx_data),
    .get_tx_packet_data (get_tx_packet_data),
    .clear              (clear),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic       st;
    logic       gt;
    logic [7:0] d;
    int         exp_occ;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle on the falling edge, let the rising edge sample it, then advance the model.
  task automatic step(input logic rst, input logic clr, input logic st, input logic gt, input logic [7:0] d);
    @(negedge clk);
    n_rst = rst;
    clear = clr;
    store_tx_data = st;
    get_tx_packet_data = gt;
    tx_data = d;
    @(posedge clk);
    #1;
    if (rst || clr) begin
      model_q.delete();
      model_out = 8'h00;
    end else begin
      bit popped = 1'b0;
      if (gt && model_q.size() > 0) begin
        model_out = model_q.pop_front();
        popped = 1'b1;
      end
      if (st && model_q.size() < 64) model_q.push_back(d);
    end
  endtask

  task automatic check_model(input string name);
    check({name, "_occ"}, int'(buffer_occupancy), model_q.size());
    check({name, "_data"}, int'(tx_packet_data), int'(model_out));
  endtask

  function automatic vec_t mk(input logic rst, input logic clr, input logic st, input logic gt,
                              input logic [7:0] d, input int occ, input logic [7:0] out);
    vec_t v;
    v.rst = rst; v.clr = clr; v.st = st; v.gt = gt; v.d = d;
    v.exp_occ = occ; v.exp_out = out;
    return v;
  endfunction

  initial begin
    // Reset, push 1..5, pop 5, underflow, simultaneous push/pop at 0 and at 3, clear with store.
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 1, 8'h77, 0, 8'h00));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 1, 0, 8'(i), i, 8'h00));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 0, 1, 8'h00, 5 - i, 8'(i)));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 8'h05));
    vecs.push_back(mk(0, 0, 1, 1, 8'h30, 1, 8'h05));
    vecs.push_back(mk(0, 0, 1, 0, 8'h31, 2, 8'h05));
    vecs.push_back(mk(0, 0, 1, 0, 8'h32, 3, 8'h05));
    vecs.push_back(mk(0, 0, 1, 1, 8'h20, 3, 8'h30));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 2, 8'h31));
    vecs.push_back(mk(0, 1, 1, 1, 8'h99, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 8'h00));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].st, vecs[i].gt, vecs[i].d);
      check($sformatf("vec%0d_occ", i), int'(buffer_occupancy), vecs[i].exp_occ);
      check($sformatf("vec%0d_data", i), int'(tx_packet_data), int'(vecs[i].exp_out));
    end

    // Fill and overflow.
    for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 8'(i));
    check("fill_occ", int'(buffer_occupancy), 64);
    step(0, 0, 1, 0, 8'hAA);
    check("overflow_occ", int'(buffer_occupancy), 64);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 1, 8'h00);
      check($sformatf("drain%0d_data", i), int'(tx_packet_data), i);
    end
    check("drain_occ", int'(buffer_occupancy), 0);

    // Underflow holds the last byte.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 8'h00);
      check("underflow_occ", int'(buffer_occupancy), 0);
      check("underflow_data", int'(tx_packet_data), 8'h3F);
    end

    // Wrap, then clear alongside a store.
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 8'(i + 8'h40));
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 8'h00);
    check_model("wrap_pop");
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 8'(i + 8'h80));
    check("wrap_occ", int'(buffer_occupancy), 50);
    step(0, 1, 1, 0, 8'hC3);
    check("clear_occ", int'(buffer_occupancy), 0);
    check("clear_data", int'(tx_packet_data), 0);
    step(0, 0, 1, 0, 8'h55);
    step(0, 0, 0, 1, 8'h00);
    check("post_clear_data", int'(tx_packet_data), 8'h55);

    // Simultaneous push/pop while full.
    for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 8'(i) ^ 8'h80);
    step(0, 0, 1, 1, 8'hEE);
    check("full_pp_occ", int'(buffer_occupancy), 64);
    check("full_pp_data", int'(tx_packet_data), 8'h80);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, 1, 8'h00);
      check_model("full_drain");
    end
    check("full_drain_last", int'(tx_packet_data), 8'hEE);

    // Randomized traffic: fill-biased, then drain-biased phases, with rare clears and resets.
    for (int i = 0; i < 3000; i++) begin
      int pst = (i % 1000 < 500) ? 3 : 1;
      logic st = ($urandom_range(3) < pst);
      logic gt = ($urandom_range(3) >= pst);
      logic clr = ($urandom_range(127) == 0);
      logic rst = ($urandom_range(511) == 0);
      step(rst, clr, st, gt, 8'($urandom));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
